// File: rtl/mux8_rr_arbiter.sv
// Eight-way round-robin arbiter driving a shared 1-bit select path.
// A grantee may make up to MAX_HOLD transfers before the grant passes on.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       dout,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] LAST = 4'(MAX_HOLD - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] ptr;

  logic       xfer;
  logic       release_now;
  logic [2:0] after_sel;

  // First set bit of v, scanning upward from s with wrap; lowest offset wins.
  function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] s);
    logic [2:0] idx;
    pick = s;
    for (int i = 7; i >= 0; i--) begin
      idx = s + 3'(i);
      if (v[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    xfer        = req[sel];
    release_now = !xfer || (cnt == LAST);
    after_sel   = sel + 3'd1;
  end

  always_comb begin
    gnt = 8'h00;
    if (state == GRANT) gnt[sel] = 1'b1;
  end

  assign busy = (state == GRANT);

  // Handover on release searches from sel+1, so the releasing requester ranks last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 3'd0;
      ptr       <= 3'd0;
      cnt       <= 4'd0;
      dout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (req != 8'h00) begin
            sel   <= pick(req, ptr);
            cnt   <= 4'd0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            dout      <= din[sel];
            out_valid <= 1'b1;
            cnt       <= cnt + 4'd1;
          end else begin
            out_valid <= 1'b0;
          end
          if (release_now) begin
            ptr <= after_sel;
            if (req != 8'h00) begin
              sel <= pick(req, after_sel);
              cnt <= 4'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
